mem_arbiter: RTL and testbench

Sequential arbiter that shares the single-port system RAM between the instruction-fetch and data-access request paths of the processor. It sits between the request unit and caches on one side and the RAM on the other. It grants one requester at a time, holds the grant until the RAM reports the access complete, gives data priority with a starvation guard for fetch, and drives the per-side wait signals the datapath stalls on.

---
 rtl/cpu_types_pkg.sv | 20 ++
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared processor types: machine word, RAM handshake state and the
// memory arbiter's grant state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Signal bundle between the request unit/caches, the memory arbiter and the RAM.
interface mem_arbiter_if (
  input logic CLK
);
  import cpu_types_pkg::*;

  logic      nRST;
  logic      iREN;
  word_t     iaddr;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      iwait;
  logic      dwait;
  word_t     iload;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport arb (
    input  CLK, nRST, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport tb (
    input  CLK, iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore,
    output nRST, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate
  );

endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access.
// Data has priority; after STARVE_LIMIT consecutive data grants taken while a
// fetch was waiting, the fetch is granted next. A grant is held until the RAM
// reports ACCESS (completion) or the requester withdraws.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      iwait,
  output logic      dwait,
  output word_t     iload,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  arb_state_t    state_r;
  arb_state_t    state_s;
  logic [SW-1:0] dstreak_r;
  logic [SW-1:0] dstreak_s;
  logic          dreq_s;
  logic          idone_s;
  logic          ddone_s;

  assign dreq_s = dREN | dWEN;

  // RAM enables/address decode from the grant plus live request, and next grant/streak.
  always_comb begin
    state_s   = state_r;
    dstreak_s = dstreak_r;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = 32'd0;
    ramstore  = 32'd0;
    idone_s   = 1'b0;
    ddone_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (iREN && (!dreq_s || (dstreak_r == LIMIT))) begin
          state_s = IGNT;
        end else if (dreq_s) begin
          state_s = DGNT;
        end else begin
          state_s = IDLE;
        end
      end
      IGNT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        idone_s = iREN && (ramstate == ACCESS);
        // ERROR/BUSY/FREE keep the grant so the access is simply retried.
        if (!iREN || idone_s) begin
          state_s = IDLE;
        end else begin
          state_s = IGNT;
        end
        if (idone_s) begin
          dstreak_s = {SW{1'b0}};
        end else begin
          dstreak_s = dstreak_r;
        end
      end
      DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ddone_s  = dreq_s && (ramstate == ACCESS);
        if (!dreq_s || ddone_s) begin
          state_s = IDLE;
        end else begin
          state_s = DGNT;
        end
        // Streak counts data wins only while a fetch is actually waiting.
        if (ddone_s && iREN) begin
          if (dstreak_r == LIMIT) begin
            dstreak_s = LIMIT;
          end else begin
            dstreak_s = dstreak_r + SW'(1);
          end
        end else if (ddone_s) begin
          dstreak_s = {SW{1'b0}};
        end else begin
          dstreak_s = dstreak_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign iwait = iREN & ~idone_s;
  assign dwait = dreq_s & ~ddone_s;
  assign iload = ramload;
  assign dload = ramload;

  // Grant state and starvation counter registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r   <= IDLE;
      dstreak_r <= {SW{1'b0}};
    end else begin
      state_r   <= state_s;
      dstreak_r <= dstreak_s;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared against a transaction-level model.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int LIM = 4;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  mem_arbiter_if b (.CLK(CLK));

  mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .CLK(b.CLK), .nRST(b.nRST),
    .iREN(b.iREN), .iaddr(b.iaddr),
    .dREN(b.dREN), .dWEN(b.dWEN), .daddr(b.daddr), .dstore(b.dstore),
    .iwait(b.iwait), .dwait(b.dwait), .iload(b.iload), .dload(b.dload),
    .ramREN(b.ramREN), .ramWEN(b.ramWEN), .ramaddr(b.ramaddr), .ramstore(b.ramstore),
    .ramload(b.ramload), .ramstate(b.ramstate)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who currently owns the RAM (0 none, 1 fetch, 2 data) and how many
  // data transactions in a row were served while a fetch was waiting.
  int owner = 0;
  int streak = 0;

  initial begin
    forever begin
      @(negedge CLK);
      begin
        logic dreq, done;
        logic e_ren, e_wen, e_iw, e_dw;
        logic [31:0] e_addr, e_store;
        dreq = b.dREN | b.dWEN;
        if (!b.nRST) begin
          owner = 0;
          streak = 0;
        end
        e_ren = 1'b0; e_wen = 1'b0; e_addr = 32'd0; e_store = 32'd0;
        e_iw = b.iREN; e_dw = dreq; done = 1'b0;
        if (owner == 1) begin
          e_addr = b.iaddr;
          e_ren = b.iREN;
          done = b.iREN && (b.ramstate == ACCESS);
          e_iw = b.iREN && !done;
        end else if (owner == 2) begin
          e_addr = b.daddr;
          e_store = b.dstore;
          e_wen = b.dWEN;
          e_ren = b.dREN && !b.dWEN;
          done = dreq && (b.ramstate == ACCESS);
          e_dw = dreq && !done;
        end
        check("model_ramREN", {31'd0, b.ramREN}, {31'd0, e_ren});
        check("model_ramWEN", {31'd0, b.ramWEN}, {31'd0, e_wen});
        check("model_ramaddr", b.ramaddr, e_addr);
        check("model_ramstore", b.ramstore, e_store);
        check("model_iwait", {31'd0, b.iwait}, {31'd0, e_iw});
        check("model_dwait", {31'd0, b.dwait}, {31'd0, e_dw});
        check("model_iload", b.iload, b.ramload);
        check("model_dload", b.dload, b.ramload);
        if (b.nRST) begin
          if (owner == 0) begin
            if (b.iREN && (!dreq || streak == LIM)) owner = 1;
            else if (dreq) owner = 2;
          end else if (owner == 1) begin
            if (done) streak = 0;
            if (done || !b.iREN) owner = 0;
          end else begin
            if (done) streak = b.iREN ? ((streak + 1 > LIM) ? LIM : streak + 1) : 0;
            if (done || !dreq) owner = 0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    @(negedge CLK);
  endtask

  initial begin
    int ndata;
    bit fetched;
    b.nRST = 1'b0; b.iREN = 1'b1; b.iaddr = 32'h40;
    b.dREN = 1'b0; b.dWEN = 1'b0; b.daddr = 32'd0; b.dstore = 32'd0;
    b.ramload = 32'd0; b.ramstate = FREE;

    // Reset with a fetch pending.
    settle();
    check("rst_ramREN", {31'd0, b.ramREN}, 32'd0);
    check("rst_iwait", {31'd0, b.iwait}, 32'd1);
    check("rst_ramaddr", b.ramaddr, 32'd0);
    tick(); tick();
    b.nRST = 1'b1; b.ramstate = BUSY;
    settle();
    check("idle_ramREN", {31'd0, b.ramREN}, 32'd0);

    // Fetch only: two BUSY cycles then ACCESS.
    tick(); settle();
    check("ignt_ramaddr", b.ramaddr, 32'h40);
    check("ignt_ramREN", {31'd0, b.ramREN}, 32'd1);
    check("ignt_busy1_iwait", {31'd0, b.iwait}, 32'd1);
    tick(); settle();
    check("ignt_busy2_iwait", {31'd0, b.iwait}, 32'd1);
    tick(); b.ramstate = ACCESS; b.ramload = 32'h8C010004; settle();
    check("fetch_done_iwait", {31'd0, b.iwait}, 32'd0);
    check("fetch_iload", b.iload, 32'h8C010004);
    tick(); b.iREN = 1'b0; b.ramstate = FREE; settle();
    check("after_fetch_ramREN", {31'd0, b.ramREN}, 32'd0);

    // Contention: data first, then fetch.
    tick(); b.iREN = 1'b1; b.dREN = 1'b1; b.daddr = 32'h100; b.iaddr = 32'h44;
    b.ramstate = ACCESS; settle();
    check("cont_idle_iwait", {31'd0, b.iwait}, 32'd1);
    tick(); settle();
    check("cont_dgnt_addr", b.ramaddr, 32'h100);
    check("cont_dgnt_dwait", {31'd0, b.dwait}, 32'd0);
    check("cont_dgnt_iwait", {31'd0, b.iwait}, 32'd1);
    tick(); b.dREN = 1'b0; settle();
    check("cont_idle2_ramREN", {31'd0, b.ramREN}, 32'd0);
    tick(); settle();
    check("cont_ignt_addr", b.ramaddr, 32'h44);
    check("cont_ignt_iwait", {31'd0, b.iwait}, 32'd0);
    tick(); b.iREN = 1'b0; settle();

    // Starvation guard: writes keep coming while a fetch waits.
    tick(); b.iREN = 1'b1; b.dWEN = 1'b1; b.daddr = 32'h300; b.iaddr = 32'h48;
    ndata = 0; fetched = 1'b0;
    for (int i = 0; i < 20 && !fetched; i++) begin
      settle();
      if (b.ramWEN && !b.dwait) ndata++;
      if (b.ramREN && b.ramaddr == 32'h48 && !b.iwait) fetched = 1'b1;
      else tick();
    end
    check("starve_fetched", {31'd0, fetched}, 32'd1);
    check("starve_data_count", ndata, 32'd4);
    tick(); settle();
    check("starve_idle_ramWEN", {31'd0, b.ramWEN}, 32'd0);
    tick(); settle();
    check("starve_reset_data_wins", {31'd0, b.ramWEN}, 32'd1);
    check("starve_reset_addr", b.ramaddr, 32'h300);
    tick(); b.iREN = 1'b0; b.dWEN = 1'b0; settle();

    // Write priority and ERROR retry.
    tick(); b.dREN = 1'b1; b.dWEN = 1'b1; b.daddr = 32'h200; b.dstore = 32'hDEADBEEF;
    b.ramstate = ERROR; settle();
    tick(); settle();
    check("err_ramWEN", {31'd0, b.ramWEN}, 32'd1);
    check("err_ramREN", {31'd0, b.ramREN}, 32'd0);
    check("err_dwait", {31'd0, b.dwait}, 32'd1);
    check("err_ramstore", b.ramstore, 32'hDEADBEEF);
    tick(); b.ramstate = ACCESS; settle();
    check("err_done_dwait", {31'd0, b.dwait}, 32'd0);
    check("err_done_addr", b.ramaddr, 32'h200);
    tick(); b.dREN = 1'b0; b.dWEN = 1'b0; b.ramstate = BUSY; settle();

    // Withdrawal during a BUSY data grant.
    tick(); b.dREN = 1'b1; b.daddr = 32'h204; settle();
    tick(); settle();
    check("wd_ramREN_before", {31'd0, b.ramREN}, 32'd1);
    tick(); b.dREN = 1'b0; settle();
    check("wd_ramREN_same_cycle", {31'd0, b.ramREN}, 32'd0);
    tick(); b.dREN = 1'b1; settle();
    check("wd_idle_next", {31'd0, b.ramREN}, 32'd0);

    // Reset mid-grant drops enables at once.
    tick(); settle();
    check("rst_mid_pre", {31'd0, b.ramREN}, 32'd1);
    tick(); b.nRST = 1'b0; #1;
    check("rst_mid_ramREN", {31'd0, b.ramREN}, 32'd0);
    tick(); b.nRST = 1'b1; b.dREN = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      tick();
      b.nRST     = ($urandom_range(0, 199) != 0);
      b.iREN     = ($urandom_range(0, 1) == 1);
      b.dREN     = ($urandom_range(0, 2) == 0);
      b.dWEN     = ($urandom_range(0, 3) == 0);
      b.iaddr    = $urandom;
      b.daddr    = $urandom;
      b.dstore   = $urandom;
      b.ramload  = $urandom;
      b.ramstate = ramstate_t'($urandom_range(0, 3));
    end
    settle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
